// File: rtl/id_exe_elastic_reg.sv
// ---------------------------------------------------------------------------
// id_exe_elastic_reg
//   ID->EXE pipeline stage with a valid/ready handshake, a two-entry skid
//   buffer (main entry M plus skid entry S) and flush.
//
//   - M drives every out_* port.
//   - S catches the one beat that can arrive while M is stalled.
//   - in_ready is a flop (it is the registered inverse of S.valid), so EXE
//     back-pressure never forms a combinational path back to decode.
//   - Flush (branch taken, load-use bubble) empties both entries.
//   - A bubble (out_valid = 0) always shows out_ctrl = 0 and out_aluop = 0,
//     so an empty slot can never trigger a memory access or a writeback.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   flush           discard held and incoming beats
//   in_valid/ready  upstream handshake (in_ready is registered)
//   in_ctrl         {memRead, memWrite, writeBack, aluSrc, regDst}
//   in_aluop, in_dest, in_src1, in_src2, in_rd1, in_rd2, in_se
//                   beat payload
//   out_valid/ready downstream handshake
//   out_*           payload of the head beat (entry M)
//
// Optional build macro ID_EXE_PERF_CNT_EN adds the following counters.
// Both saturate, are cleared by rst, and are not cleared by flush.
//   stall_cnt  [31:0]  cycles with out_valid & !out_ready
//   bubble_cnt [31:0]  non-reset cycles with !out_valid
// ---------------------------------------------------------------------------
module id_exe_elastic_reg #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALUOP_W    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4:0]            in_ctrl,
  input  logic [ALUOP_W-1:0]    in_aluop,
  input  logic [REG_ADDR_W-1:0] in_dest,
  input  logic [REG_ADDR_W-1:0] in_src1,
  input  logic [REG_ADDR_W-1:0] in_src2,
  input  logic [DATA_W-1:0]     in_rd1,
  input  logic [DATA_W-1:0]     in_rd2,
  input  logic [DATA_W-1:0]     in_se,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4:0]            out_ctrl,
  output logic [ALUOP_W-1:0]    out_aluop,
  output logic [REG_ADDR_W-1:0] out_dest,
  output logic [REG_ADDR_W-1:0] out_src1,
  output logic [REG_ADDR_W-1:0] out_src2,
  output logic [DATA_W-1:0]     out_rd1,
  output logic [DATA_W-1:0]     out_rd2,
  output logic [DATA_W-1:0]     out_se
`ifdef ID_EXE_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cnt,
  output logic [31:0]           bubble_cnt
`endif
);

  // Header = ctrl + aluop (cleared on bubbles); body = addresses + data.
  localparam int HDR_W  = 5 + ALUOP_W;
  localparam int BODY_W = 3 * REG_ADDR_W + 3 * DATA_W;
  localparam int BEAT_W = HDR_W + BODY_W;

  logic [BEAT_W-1:0] r_m;
  logic [BEAT_W-1:0] r_s;
  logic              r_m_valid;
  logic              r_s_valid;
  logic              r_in_ready;

  logic [BEAT_W-1:0] w_in_beat;
  logic [BEAT_W-1:0] w_m_nx;
  logic [BEAT_W-1:0] w_s_nx;
  logic              w_m_valid_nx;
  logic              w_s_valid_nx;
  logic              w_accept;
  logic              w_emit;

  assign w_in_beat = {in_ctrl, in_aluop, in_dest, in_src1, in_src2,
                      in_rd1, in_rd2, in_se};
  assign w_accept  = in_valid & r_in_ready;
  assign w_emit    = r_m_valid & out_ready;

  // Next-state of the M/S entries; flush wins over every handshake.
  always_comb begin
    w_m_nx       = r_m;
    w_s_nx       = r_s;
    w_m_valid_nx = r_m_valid;
    w_s_valid_nx = r_s_valid;
    if (flush) begin
      // Data fields keep their last value; only the header is made safe.
      w_m_valid_nx                 = 1'b0;
      w_s_valid_nx                 = 1'b0;
      w_m_nx[BEAT_W-1 -: HDR_W]    = {HDR_W{1'b0}};
    end else if (!r_m_valid || w_emit) begin
      if (r_s_valid) begin
        // in_ready was low, so nothing can be accepted in this cycle.
        w_m_nx       = r_s;
        w_m_valid_nx = 1'b1;
        w_s_valid_nx = 1'b0;
      end else if (w_accept) begin
        w_m_nx       = w_in_beat;
        w_m_valid_nx = 1'b1;
      end else begin
        w_m_valid_nx              = 1'b0;
        w_m_nx[BEAT_W-1 -: HDR_W] = {HDR_W{1'b0}};
      end
    end else if (w_accept) begin
      // M is full and stalled: the accepted beat parks in S.
      w_s_nx       = w_in_beat;
      w_s_valid_nx = 1'b1;
    end else begin
      w_s_valid_nx = r_s_valid;
    end
  end

  // State registers; in_ready is the registered inverse of next S.valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_m        <= {BEAT_W{1'b0}};
      r_s        <= {BEAT_W{1'b0}};
      r_m_valid  <= 1'b0;
      r_s_valid  <= 1'b0;
      r_in_ready <= 1'b1;
    end else begin
      r_m        <= w_m_nx;
      r_s        <= w_s_nx;
      r_m_valid  <= w_m_valid_nx;
      r_s_valid  <= w_s_valid_nx;
      r_in_ready <= ~w_s_valid_nx;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_m_valid;
  assign {out_ctrl, out_aluop, out_dest, out_src1, out_src2,
          out_rd1, out_rd2, out_se} = r_m;

`ifdef ID_EXE_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_bubble_cnt;

  // Saturating stall / bubble counters; only rst clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt  <= 32'd0;
      r_bubble_cnt <= 32'd0;
    end else begin
      if (r_m_valid && !out_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end else begin
        r_stall_cnt <= r_stall_cnt;
      end
      if (!r_m_valid && (r_bubble_cnt != 32'hFFFF_FFFF)) begin
        r_bubble_cnt <= r_bubble_cnt + 32'd1;
      end else begin
        r_bubble_cnt <= r_bubble_cnt;
      end
    end
  end

  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;
`else
  // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_id_exe_elastic_reg.sv
module tb_id_exe_elastic_reg;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [4:0]  in_ctrl, out_ctrl;
  logic [2:0]  in_aluop, out_aluop;
  logic [4:0]  in_dest, in_src1, in_src2, out_dest, out_src1, out_src2;
  logic [31:0] in_rd1, in_rd2, in_se, out_rd1, out_rd2, out_se;
`ifdef ID_EXE_PERF_CNT_EN
  logic [31:0] stall_cnt, bubble_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  id_exe_elastic_reg #(.DATA_W(32), .REG_ADDR_W(5), .ALUOP_W(3)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_aluop(in_aluop), .in_dest(in_dest),
    .in_src1(in_src1), .in_src2(in_src2),
    .in_rd1(in_rd1), .in_rd2(in_rd2), .in_se(in_se),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_aluop(out_aluop), .out_dest(out_dest),
    .out_src1(out_src1), .out_src2(out_src2),
    .out_rd1(out_rd1), .out_rd2(out_rd2), .out_se(out_se)
`ifdef ID_EXE_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  // Every payload field is derived from a beat id so a whole beat can be
  // checked from the id alone. ctrl/aluop are forced nonzero.
  function automatic logic [4:0] f_ctrl(input logic [31:0] id);
    return id[4:0] | 5'b00001;
  endfunction
  function automatic logic [2:0] f_aluop(input logic [31:0] id);
    return id[2:0] | 3'b001;
  endfunction

  typedef struct {
    logic        iv;
    logic [31:0] id;
    logic        ordy;
    logic        fl;
    logic        ov;
    logic [31:0] eid;
    logic        ir;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic fl, input logic iv,
                       input logic [31:0] id, input logic ordy);
    rst       = r;
    flush     = fl;
    in_valid  = iv;
    out_ready = ordy;
    in_ctrl   = f_ctrl(id);
    in_aluop  = f_aluop(id);
    in_dest   = id[4:0];
    in_src1   = id[4:0] + 5'd1;
    in_src2   = id[4:0] + 5'd2;
    in_rd1    = id;
    in_rd2    = ~id;
    in_se     = {id[30:0], 1'b0};
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic ov, input logic [31:0] eid,
                           input logic ir);
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, ov});
    chk({tag, ".in_ready"},  {31'd0, in_ready},  {31'd0, ir});
    if (ov) begin
      chk({tag, ".rd1"},   out_rd1, eid);
      chk({tag, ".rd2"},   out_rd2, ~eid);
      chk({tag, ".se"},    out_se, {eid[30:0], 1'b0});
      chk({tag, ".ctrl"},  {27'd0, out_ctrl}, {27'd0, f_ctrl(eid)});
      chk({tag, ".aluop"}, {29'd0, out_aluop}, {29'd0, f_aluop(eid)});
      chk({tag, ".dest"},  {27'd0, out_dest}, {27'd0, eid[4:0]});
      chk({tag, ".src1"},  {27'd0, out_src1}, {27'd0, eid[4:0] + 5'd1});
      chk({tag, ".src2"},  {27'd0, out_src2}, {27'd0, eid[4:0] + 5'd2});
    end else begin
      chk({tag, ".bubble_ctrl"},  {27'd0, out_ctrl}, 32'd0);
      chk({tag, ".bubble_aluop"}, {29'd0, out_aluop}, 32'd0);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, ".in_ready"},  {31'd0, in_ready},  32'd1);
    chk({tag, ".ctrl"},      {27'd0, out_ctrl},  32'd0);
    chk({tag, ".aluop"},     {29'd0, out_aluop}, 32'd0);
    chk({tag, ".dest"},      {27'd0, out_dest},  32'd0);
    chk({tag, ".src1"},      {27'd0, out_src1},  32'd0);
    chk({tag, ".src2"},      {27'd0, out_src2},  32'd0);
    chk({tag, ".rd1"},       out_rd1, 32'd0);
    chk({tag, ".rd2"},       out_rd2, 32'd0);
    chk({tag, ".se"},        out_se,  32'd0);
  endtask

  initial begin
    // Streaming: ids 1..8 out one cycle later, in_ready stays 1.
    for (int k = 1; k <= 8; k++) vt.push_back('{1'b1, k, 1'b1, 1'b0, 1'b1, k, 1'b1});
    vt.push_back('{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1});
    // Stall: A in M, B in S, C refused; then A, B drain in order.
    vt.push_back('{1'b1, 32'h10, 1'b0, 1'b0, 1'b1, 32'h10, 1'b1});
    vt.push_back('{1'b1, 32'h11, 1'b0, 1'b0, 1'b1, 32'h10, 1'b0});
    vt.push_back('{1'b1, 32'h12, 1'b0, 1'b0, 1'b1, 32'h10, 1'b0});
    vt.push_back('{1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h11, 1'b1});
    vt.push_back('{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1});
    // Flush with M and S full and a beat offered.
    vt.push_back('{1'b1, 32'h20, 1'b0, 1'b0, 1'b1, 32'h20, 1'b1});
    vt.push_back('{1'b1, 32'h21, 1'b0, 1'b0, 1'b1, 32'h20, 1'b0});
    vt.push_back('{1'b1, 32'h22, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1});
    vt.push_back('{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1});
    vt.push_back('{1'b1, 32'h23, 1'b1, 1'b0, 1'b1, 32'h23, 1'b1});
    vt.push_back('{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1});
    // Bubble: ctrl 5'b11111 offered with in_valid = 0.
    vt.push_back('{1'b0, 32'h1F, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1});
    vt.push_back('{1'b0, 32'h1F, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1});

    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    check_zero("reset");

    foreach (vt[i]) begin
      drive(1'b0, vt[i].fl, vt[i].iv, vt[i].id, vt[i].ordy);
      check_out($sformatf("vec%0d", i), vt[i].ov, vt[i].eid, vt[i].ir);
    end

    // Reset mid-stall with S full, a beat offered during reset.
    drive(1'b0, 1'b0, 1'b1, 32'h30, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 32'h31, 1'b0);
    check_out("rst_pre", 1'b1, 32'h30, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 32'h32, 1'b0);
    check_zero("rst_mid");
    drive(1'b0, 1'b0, 1'b1, 32'h33, 1'b1);
    check_out("rst_post", 1'b1, 32'h33, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check_out("rst_drain", 1'b0, 32'h0, 1'b1);

    // Flush while M emits and S is empty; offered beat dropped.
    drive(1'b0, 1'b0, 1'b1, 32'h40, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 32'h41, 1'b1);
    check_out("flush_emit", 1'b0, 32'h0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check_out("flush_emit2", 1'b0, 32'h0, 1'b1);

`ifdef ID_EXE_PERF_CNT_EN
    // 1 bubble (first cycle), 3 stall cycles, emit, then 1 more bubble.
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("perf_rst_stall",  stall_cnt,  32'd0);
    chk("perf_rst_bubble", bubble_cnt, 32'd0);
    drive(1'b0, 1'b0, 1'b1, 32'h50, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("perf_stall",  stall_cnt,  32'd3);
    chk("perf_bubble", bubble_cnt, 32'd2);
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("perf_flush_keeps", stall_cnt, 32'd3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
